// File: rtl/imm_gen_pkg.sv
// Immediate-format enum, base-ISA opcodes and the pure RV instruction-to-immediate decoder.
// Decoder is combinational and width-independent (64-bit result, truncated by the user).
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_t;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef struct packed {
    imm_fmt_t    fmt;
    logic [63:0] imm;
  } imm_dec_t;

  // Sign-extended to 64 bits; a 32-bit consumer takes the low half, which stays correct.
  function automatic imm_dec_t imm_decode(input logic [31:0] instr);
    imm_dec_t d;
    d.fmt = FMT_NONE;
    d.imm = '0;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        d.fmt = FMT_I;
        d.imm = {{52{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        d.fmt = FMT_S;
        d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        d.fmt = FMT_B;
        d.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        d.fmt = FMT_U;
        d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        d.fmt = FMT_J;
        d.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic 2-entry valid/ready skid register; latency 1, in_ready is a pure flop output.
// Backpressure: holds up to two beats, in_ready drops only once the skid entry is occupied.
module imm_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_vld_q, main_vld_d;
  logic [W-1:0] main_dat_q, main_dat_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         accept;
  logic         drain;

  assign in_ready  = !skid_vld_q;
  assign out_valid = main_vld_q;
  assign out_data  = main_dat_q;
  assign accept    = in_valid && !skid_vld_q;
  assign drain     = main_vld_q && out_ready;

  always_comb begin
    main_vld_d = main_vld_q;
    main_dat_d = main_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    if (flush) begin
      main_vld_d = 1'b0;
      main_dat_d = '0;
      skid_vld_d = 1'b0;
      skid_dat_d = '0;
    end else if (drain) begin
      // in_ready is low whenever skid is full, so refill and accept never coincide
      if (skid_vld_q) begin
        main_dat_d = skid_dat_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_dat_d = in_data;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (main_vld_q) begin
        skid_vld_d = 1'b1;
        skid_dat_d = in_data;
      end else begin
        main_vld_d = 1'b1;
        main_dat_d = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_vld_q <= 1'b0;
      main_dat_q <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      main_dat_q <= main_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
    end
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered RV immediate-generation stage, latency 1, fully registered in_ready via skid buffer.
// IMM_GEN_ILLEGAL_EN adds out_illegal for non-32-bit encodings or unrecognised opcodes.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt
`ifdef IMM_GEN_ILLEGAL_EN
  ,
  output logic            out_illegal
`endif
);

`ifdef IMM_GEN_ILLEGAL_EN
  localparam int ILL_W = 1;
`else
  localparam int ILL_W = 0;
`endif
  localparam int W = 32 + PC_W + XLEN + 3 + ILL_W;

  imm_dec_t    dec;
  logic [W-1:0] in_data;
  logic [W-1:0] out_data;
  logic [2:0]   fmt_bits;

  assign dec = imm_decode(in_instr);

`ifdef IMM_GEN_ILLEGAL_EN
  assign in_data = {in_instr, in_pc, dec.imm[XLEN-1:0], dec.fmt,
                    (in_instr[1:0] != 2'b11) || (dec.fmt == FMT_NONE)};
  assign {out_instr, out_pc, out_imm, fmt_bits, out_illegal} = out_data;
`else
  assign in_data = {in_instr, in_pc, dec.imm[XLEN-1:0], dec.fmt};
  assign {out_instr, out_pc, out_imm, fmt_bits} = out_data;
`endif

  assign out_fmt = imm_fmt_t'(fmt_bits);

  imm_skid_buf #(.W(W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered RV64 immediate-generation stage sitting between fetch and register-read in the pipelined core. It accepts one 32-bit instruction per cycle over a valid/ready handshake, classifies its format (I/S/B/U/J), produces the sign-extended XLEN-bit immediate, and presents it one cycle later. A two-entry skid buffer keeps `in_ready` registered so backpressure never forms a combinational path. Successor to the fixed 64-bit, 3-format combinational extractor: full base-ISA format coverage, parametrised width, flush support.

## Interface
- `XLEN`, 64, immediate output width; 32 or 64 only.
- `PC_W`, 64, width of the PC carried alongside the instruction.
- `clk` input 1 system clock, rising edge.
- `reset` input 1 synchronous, active-high.
- `flush` input 1 synchronous pipeline kill; drops all held entries.
- `in_valid` input 1 upstream beat valid.
- `in_ready` output 1 stage can accept a beat.
- `in_instr` input 32 instruction word.
- `in_pc` input PC_W instruction address.
- `out_valid` output 1 output beat valid.
- `out_ready` input 1 downstream accepts beat.
- `out_instr` output 32 registered instruction passthrough.
- `out_pc` output PC_W registered PC passthrough.
- `out_imm` output XLEN sign-extended immediate.
- `out_fmt` output 3 format code (`imm_fmt_t`).
- `out_illegal` output 1 present only with `IMM_GEN_ILLEGAL_EN`.

## Operation
- Decode on `in_instr[6:0]`: LOAD 0000011, OP-IMM 0010011, OP-IMM-32 0011011, JALR 1100111 → I; STORE 0100011 → S; BRANCH 1100011 → B; LUI 0110111, AUIPC 0010111 → U; JAL 1101111 → J; anything else → NONE, imm 0.
- I: instr[31:20]. S: {instr[31:25], instr[11:7]}. B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}. U: {instr[31:12], 12'b0}. J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Every format sign-extends from instr[31] to XLEN; U on XLEN=64 sign-extends bit 31. Shift-immediates use plain I extraction (no special shamt handling).
- Storage: main entry (drives outputs) + skid entry. Payload = {instr, pc, imm, fmt[, illegal]}.
- Transfer on input when `in_valid && in_ready`; on output when `out_valid && out_ready`.
- Accept with main empty or main draining this cycle → beat goes to main. Accept while main held (not draining) → beat goes to skid. Main drains while skid full → skid moves to main, skid empties.
- `in_ready = !skid_valid` (pure register output).
- `flush`: both entries invalid next cycle; any concurrent input beat discarded; `flush` wins over every other event.

## Timing
- Latency 1: beat accepted at edge N is on outputs after edge N (visible cycle N+1) when main was empty or draining.
- Throughput 1 beat/cycle with `out_ready` held high.
- Reset (and flush) values: `out_valid`=0, skid valid=0, `out_imm`=0, `out_fmt`=FMT_NONE, `out_instr`=0, `out_pc`=0, `out_illegal`=0; `in_ready`=1 from first cycle after the reset edge.
- Reset mid-stream: held beats lost, no output handshake completes on the reset edge.
- Outputs stable while `out_valid && !out_ready`.
- After 2 accepts with `out_ready`=0, `in_ready` drops to 0 the next cycle; rises the cycle after the first output handshake.

## Configuration
- `IMM_GEN_ILLEGAL_EN` defined: `out_illegal` port exists; set when `in_instr[1:0] != 2'b11` or opcode unrecognised; `out_fmt`=FMT_NONE, `out_imm`=0 on such beats.
- Undefined: port absent; same beats still pass with FMT_NONE/imm 0, no flag.

## Structure
- `imm_gen_pkg`: `imm_fmt_t` enum (FMT_NONE=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J), opcode localparams, pure decode function `imm_decode(instr) → {fmt, imm}`.
- Sub-module `imm_skid_buf` (parameter `W` payload width): generic 2-entry valid/ready skid register, reusable elsewhere in the pipeline. Top = decode function + one `imm_skid_buf` instance.

## Test plan
- XLEN=64, `0xFFF00093` (addi x1,x0,-1) → `out_imm`=0xFFFF_FFFF_FFFF_FFFF, FMT_I, one cycle later.
- `0xFE112E23` (sw x1,-4(x2)) → 0xFFFF_FFFF_FFFF_FFFC FMT_S; `0xFE000CE3` (beq -8) → 0xFFFF_FFFF_FFFF_FFF8 FMT_B.
- `0x123450B7` → 0x0000_0000_1234_5000 FMT_U; `0x800000B7` → 0xFFFF_FFFF_8000_0000; `0x0010006F` (jal +2048) → 0x800 FMT_J.
- `out_ready`=0, three back-to-back beats → first two accepted, `in_ready`=0 for third; raise `out_ready` → beats emerge in order, no loss/duplication.
- `flush` with both entries full and `in_valid`=1 → `out_valid`=0, `in_ready`=1 next cycle, flushed beats never appear.
- `0x00000013` with instr[1:0] forced to 00 under `IMM_GEN_ILLEGAL_EN` → `out_illegal`=1, FMT_NONE, imm 0.
